// File: rtl/exp_subtractor.sv
// exp_subtractor: quotient exponent path for the floating-point divider.
// Two-stage valid/ready pipeline computing exp_q = exp_a - exp_b + BIAS - norm_dec,
// saturated, with divide-by-zero, special-operand, overflow and underflow flags.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready is combinational, no bubbles)
//   exp_a, exp_b        dividend / divisor biased exponents
//   norm_dec            1 = quotient mantissa needs a 1-bit left normalize
//   out_valid/out_ready output handshake; outputs hold while stalled
//   exp_q               biased quotient exponent (saturated)
//   ovf, unf, dbz, spec result flags, at most one high per beat
module exp_subtractor #(
  parameter int EW   = 8,
  parameter int BIAS = 127
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EW-1:0] exp_a,
  input  logic [EW-1:0] exp_b,
  input  logic          norm_dec,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] exp_q,
  output logic          ovf,
  output logic          unf,
  output logic          dbz,
  output logic          spec
);
  // Two guard bits keep the full difference and bias range signed without wrap.
  localparam int DW = EW + 2;
  localparam logic [EW-1:0]        ONES   = '1;
  localparam logic [DW-1:0]        BIAS_W = DW'(BIAS);
  localparam logic signed [DW-1:0] R_MAX  = DW'(2**EW - 2);
  localparam logic signed [DW-1:0] R_ONE  = DW'(1);
  logic          s2_adv, s1_adv, load1, load2;
  logic          s1_valid_q, s1_valid_d;
  logic [DW-1:0] s1_d_q, s1_d_d;
  logic          s1_nd_q, s1_nd_d;
  logic          s1_spec_q, s1_spec_d;
  logic          s1_za_q, s1_za_d;
  logic          s1_zb_q, s1_zb_d;
  logic          s2_valid_q, s2_valid_d;
  logic [EW-1:0] s2_exp_q, s2_exp_d;
  logic          s2_ovf_q, s2_ovf_d;
  logic          s2_unf_q, s2_unf_d;
  logic          s2_dbz_q, s2_dbz_d;
  logic          s2_spec_q, s2_spec_d;
  logic [DW-1:0] r;
  logic          is_ovf, is_unf, normal, f_dbz, f_ovf, f_unf;
  logic [EW-1:0] res;
  always_comb begin
    s2_adv     = ~s2_valid_q | out_ready;
    s1_adv     = ~s1_valid_q | s2_adv;
    in_ready   = s1_adv;
    load1      = s1_adv & in_valid;
    load2      = s2_adv & s1_valid_q;
    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    s1_d_d     = load1 ? {2'b00, exp_a} - {2'b00, exp_b} : s1_d_q;
    s1_nd_d    = load1 ? norm_dec : s1_nd_q;
    s1_spec_d  = load1 ? (exp_a == ONES) | (exp_b == ONES) : s1_spec_q;
    s1_za_d    = load1 ? exp_a == '0 : s1_za_q;
    s1_zb_d    = load1 ? exp_b == '0 : s1_zb_q;
    r          = s1_d_q + BIAS_W - {{(DW-1){1'b0}}, s1_nd_q};
    is_ovf     = $signed(r) > R_MAX;
    is_unf     = $signed(r) < R_ONE;
    // Zero dividend outranks divide-by-zero so 0/0 leaves with no flags.
    normal     = ~s1_spec_q & ~s1_za_q & ~s1_zb_q;
    f_dbz      = ~s1_spec_q & ~s1_za_q & s1_zb_q;
    f_ovf      = normal & is_ovf;
    f_unf      = normal & ~is_ovf & is_unf;
    res        = (s1_spec_q | f_dbz | f_ovf) ? ONES :
                 (s1_za_q | f_unf) ? '0 : r[EW-1:0];
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_exp_d   = load2 ? res : s2_exp_q;
    s2_ovf_d   = load2 ? f_ovf : s2_ovf_q;
    s2_unf_d   = load2 ? f_unf : s2_unf_q;
    s2_dbz_d   = load2 ? f_dbz : s2_dbz_q;
    s2_spec_d  = load2 ? s1_spec_q : s2_spec_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_d_q     <= '0;
      s1_nd_q    <= 1'b0;
      s1_spec_q  <= 1'b0;
      s1_za_q    <= 1'b0;
      s1_zb_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_exp_q   <= '0;
      s2_ovf_q   <= 1'b0;
      s2_unf_q   <= 1'b0;
      s2_dbz_q   <= 1'b0;
      s2_spec_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_d_q     <= s1_d_d;
      s1_nd_q    <= s1_nd_d;
      s1_spec_q  <= s1_spec_d;
      s1_za_q    <= s1_za_d;
      s1_zb_q    <= s1_zb_d;
      s2_valid_q <= s2_valid_d;
      s2_exp_q   <= s2_exp_d;
      s2_ovf_q   <= s2_ovf_d;
      s2_unf_q   <= s2_unf_d;
      s2_dbz_q   <= s2_dbz_d;
      s2_spec_q  <= s2_spec_d;
    end
  end
  assign out_valid = s2_valid_q;
  assign exp_q     = s2_exp_q;
  assign ovf       = s2_ovf_q;
  assign unf       = s2_unf_q;
  assign dbz       = s2_dbz_q;
  assign spec      = s2_spec_q;
endmodule

// File: tb/tb_exp_subtractor.sv
// tb_exp_subtractor: directed self-checking bench for exp_subtractor.
module tb_exp_subtractor;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] exp_a = '0;
  logic [7:0] exp_b = '0;
  logic       norm_dec = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] exp_q;
  logic       ovf, unf, dbz, spec;
  int         n_chk = 0;
  int         n_fail = 0;
  exp_subtractor #(.EW(8), .BIAS(127)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .exp_a(exp_a), .exp_b(exp_b), .norm_dec(norm_dec),
    .out_valid(out_valid), .out_ready(out_ready), .exp_q(exp_q),
    .ovf(ovf), .unf(unf), .dbz(dbz), .spec(spec)
  );
  always #5 clk = ~clk;
  // flags packed as {ovf, unf, dbz, spec}
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       nd;
    logic [7:0] e;
    logic [3:0] f;
  } vec_t;
  vec_t vecs[16];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // One beat with an idle output side: accepted at the next posedge,
  // out_valid must be low one cycle later and high with the result two cycles later.
  task automatic send_one(input string name, input vec_t v);
    @(negedge clk);
    in_valid = 1'b1; exp_a = v.a; exp_b = v.b; norm_dec = v.nd;
    #1 check({name, " in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({name, " early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({name, " result"}, {19'd0, out_valid, exp_q, ovf, unf, dbz, spec}, {19'd0, 1'b1, v.e, v.f});
  endtask
  initial begin
    int got, sent;
    logic [7:0] bp_exp[6];
    vecs[0]  = '{8'd130, 8'd127, 1'b0, 8'd130, 4'b0000};
    vecs[1]  = '{8'd128, 8'd127, 1'b1, 8'd127, 4'b0000};
    vecs[2]  = '{8'd254, 8'd127, 1'b0, 8'd254, 4'b0000};
    vecs[3]  = '{8'd254, 8'd126, 1'b0, 8'd255, 4'b1000};
    vecs[4]  = '{8'd1,   8'd200, 1'b0, 8'd0,   4'b0100};
    vecs[5]  = '{8'd1,   8'd127, 1'b0, 8'd1,   4'b0000};
    vecs[6]  = '{8'd1,   8'd127, 1'b1, 8'd0,   4'b0100};
    vecs[7]  = '{8'd5,   8'd0,   1'b0, 8'd255, 4'b0010};
    vecs[8]  = '{8'd0,   8'd0,   1'b0, 8'd0,   4'b0000};
    vecs[9]  = '{8'd255, 8'd0,   1'b0, 8'd255, 4'b0001};
    vecs[10] = '{8'd0,   8'd255, 1'b0, 8'd255, 4'b0001};
    vecs[11] = '{8'd10,  8'd255, 1'b1, 8'd255, 4'b0001};
    vecs[12] = '{8'd0,   8'd5,   1'b1, 8'd0,   4'b0000};
    vecs[13] = '{8'd200, 8'd1,   1'b0, 8'd255, 4'b1000};
    vecs[14] = '{8'd100, 8'd100, 1'b1, 8'd126, 4'b0000};
    vecs[15] = '{8'd255, 8'd255, 1'b0, 8'd255, 4'b0001};
    #2;
    check("reset outputs", {26'd0, out_valid, ovf, unf, dbz, spec, |exp_q}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("in_ready after reset", 32'(in_ready), 32'd1);
    foreach (vecs[i]) send_one($sformatf("vec%0d", i), vecs[i]);
    // Backpressure: six back-to-back beats, out_ready low for the first six cycles.
    for (int k = 0; k < 6; k++) bp_exp[k] = 8'(130 + k - (k % 2));
    got = 0; sent = 0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      @(negedge clk);
      out_ready = (c >= 6);
      in_valid = (sent < 6);
      exp_a = 8'(130 + sent); exp_b = 8'd127; norm_dec = sent[0];
      #1;
      if (c >= 2 && c < 6)
        check($sformatf("stall c%0d", c), {22'd0, out_valid, in_ready, exp_q}, {22'd0, 1'b1, 1'b0, bp_exp[0]});
      if (out_valid && out_ready) begin
        check($sformatf("drain beat%0d", got), {23'd0, ovf | unf | dbz | spec, exp_q}, {23'd0, 1'b0, bp_exp[got]});
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("drain count", 32'(got), 32'd6);
    #1 check("no duplicate", 32'(out_valid), 32'd0);
    // Reset with two beats in flight.
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; exp_a = 8'd140; exp_b = 8'd127; norm_dec = 1'b0;
    @(negedge clk);
    exp_a = 8'd150;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre-reset valid", {23'd0, out_valid, exp_q}, {23'd0, 1'b1, 8'd140});
    rst = 1'b1;
    #1 check("reset drops out_valid", {23'd0, out_valid, exp_q}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("no stale after reset", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("no stale after reset 2", 32'(out_valid), 32'd0);
    send_one("post-reset", vecs[0]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
